mult16_shift_add: RTL and testbench
===================================

// Module: mult16_shift_add
// PURPOSE
//  Sequential unsigned WIDTHxWIDTH shift-add multiplier for the multicycle RISC datapath.
//  Sits directly upstream of the FA16b adder: each step it drives the adder's A/B/Cin
//  and consumes the Sum/Cout it returns the same cycle.
//  Produces one 2*WIDTH-bit product per start request, in WIDTH+1 cycles.
// PARAMETERS
//  WIDTH  16  operand width; must match adder width (FA16b => 16)
// PORTS
//  clk           in   1        single clock, rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  start         in   1        request; sampled only in IDLE
//  mcand         in   WIDTH    multiplicand, latched on accepted start
//  mplier        in   WIDTH    multiplier, latched on accepted start
//  busy          out  1        high while in CALC
//  done          out  1        one-cycle pulse, product valid
//  product       out  2*WIDTH  result register, held until next completion
//  add_a         out  WIDTH    to FA16b.A
//  add_b         out  WIDTH    to FA16b.B
//  add_cin       out  1        to FA16b.Cin
//  add_sum       in   WIDTH    from FA16b.Sum (combinational, same cycle)
//  add_cout      in   1        from FA16b.Cout
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; hi, lo, mc, count, product = 0; busy=0, done=0.
//  - FSM states IDLE, CALC, DONE:
//    IDLE: start=1 at edge -> mc<=mcand, lo<=mplier, hi<=0, count<=0, go CALC.
//    CALC: one step per edge; after the WIDTH-th step (count=WIDTH-1) -> go DONE
//          and product<={new hi,new lo}.
//    DONE: done=1 for exactly this cycle; next edge -> IDLE unconditionally.
//  - Step (CALC only): add_a=hi, add_b=lo[0]?mc:0, add_cin=0;
//    hi<={add_cout, add_sum[WIDTH-1:1]}; lo<={add_sum[0], lo[WIDTH-1:1]}; count++.
//  - Outside CALC: add_a=0, add_b=0, add_cin=0 (adder inputs quiet).
//  - Widths: hi, lo, mc = WIDTH; count = clog2(WIDTH) bits; add_cout is the 17th bit
//    and must never be dropped (all-ones operands overflow Sum).
//  - Latency: start accepted at edge e0; CALC edges e1..eWIDTH; done high during the
//    cycle after eWIDTH (WIDTH+1 cycles after e0); IDLE after e(WIDTH+1).
//  - Fixed latency: no early exit on zero operands.
//  - busy = (state==CALC); done = (state==DONE); both registered-state decodes.
//  - start while CALC or DONE: ignored, no effect on operands or result.
//  - Earliest restart: start high during DONE is ignored; start in the following
//    IDLE cycle is accepted (min issue interval WIDTH+2 cycles).
//  - mcand/mplier changing after acceptance: no effect (latched copies used).
//  - product changes only on the CALC->DONE edge and on reset; stable otherwise.
//  - Reset mid-CALC: immediate abort to IDLE, product cleared to 0, no done pulse.
// TESTING
//  1. mcand=0x0003, mplier=0x0005, start 1 cycle -> busy 16 cycles, done pulse at
//     cycle 17, product=0x0000000F.
//  2. mcand=0xFFFF, mplier=0xFFFF -> product=0xFFFE0001 (checks add_cout capture).
//  3. mcand=0x1234, mplier=0x0000 -> product=0x00000000, done still at cycle 17.
//  4. Start 0x00FF*0x0101; at CALC step 5 pulse start with 0x0002*0x0002 -> ignored,
//     product=0x0000FFFF.
//  5. Start 0x8000*0x0002; drop rst_n at CALC step 8 -> busy=0, done never pulses,
//     product=0; restart 0x0007*0x0009 -> product=0x0000003F.
//  6. Start held high continuously with 0x0010*0x0010 -> one done per 18 cycles,
//     product=0x00000100 each time; add_a/add_b=0 whenever busy=0.

Source files
------------

// File: rtl/mult16_shift_add.sv
// Sequential unsigned WIDTHxWIDTH shift-add multiplier.
// Each CALC cycle drives the external adder (FA16b) and folds its Sum/Cout into the hi/lo shift pair.
module mult16_shift_add #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mc_q, mc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state, datapath step and adder-port drive
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mc_d      = mc_q;
    count_d   = count_q;
    product_d = product_q;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mc_d    = mcand;
          lo_d    = mplier;
          hi_d    = '0;
          count_d = '0;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        add_a = hi_q;
        if (lo_q[0]) begin
          add_b = mc_q;
        end else begin
          add_b = '0;
        end
        // add_cout becomes the new top bit of hi; it carries the overflow of hi+mc
        hi_d    = {add_cout, add_sum[WIDTH-1:1]};
        lo_d    = {add_sum[0], lo_q[WIDTH-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == LAST_STEP) begin
          product_d = {add_cout, add_sum, lo_q[WIDTH-1:1]};
          state_d   = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mc_q      <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mc_q      <= mc_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mult16_shift_add.sv
// Self-checking bench for mult16_shift_add with a behavioural FA16b model on the adder ports.
// Expected products come from plain 32-bit multiplication of the issued operands.
module tb_mult16_shift_add;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;

  int          checks = 0;
  int          failures = 0;
  int          quiet_viol = 0;
  logic [31:0] exp_prod;

  always #5 clk = ~clk;

  mult16_shift_add #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin),
    .add_sum (add_sum),
    .add_cout(add_cout)
  );

  // FA16b: 16-bit ripple adder, combinational
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  // Adder inputs must stay quiet outside CALC, and carry-in is never used
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ((busy === 1'b0 && (add_a !== 16'd0 || add_b !== 16'd0)) || add_cin !== 1'b0))
      quiet_viol++;
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
  endtask

  // Observes one operation: cycle 1 is the first cycle after the accepting edge.
  task automatic run_op(input int inj, input logic [31:0] prev,
                        output int done_at, output int busy_cnt, output int done_cnt,
                        output bit early);
    done_at  = -1;
    busy_cnt = 0;
    done_cnt = 0;
    early    = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (done_at < 0 && product !== prev) early = 1'b1;
      if (c == 1) begin
        start  = 1'b0;
        mcand  = 16'($urandom);
        mplier = 16'($urandom);
      end else if (inj > 0 && c == inj) begin
        start  = 1'b1;
        mcand  = 16'h0002;
        mplier = 16'h0002;
      end else if (inj > 0 && c == inj + 1) begin
        start  = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b1;
    mcand  = 16'hFFFF;
    mplier = 16'hFFFF;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (product !== 32'h0) begin
      failures++;
      $display("FAIL reset_product got=%h required=00000000", product);
    end
    checks++;
    if (add_a !== 16'h0 || add_b !== 16'h0 || add_cin !== 1'b0) begin
      failures++;
      $display("FAIL reset_adder a=%h b=%h cin=%b required 0", add_a, add_b, add_cin);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_prod = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b required 0", busy);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [3];
    logic [15:0] tb_ [3];
    logic [31:0] tp [3];
    int d_at, b_cnt, d_cnt;
    bit early;
    ta[0] = 16'h0003; tb_[0] = 16'h0005; tp[0] = 32'h0000000F;
    ta[1] = 16'hFFFF; tb_[1] = 16'hFFFF; tp[1] = 32'hFFFE0001;
    ta[2] = 16'h1234; tb_[2] = 16'h0000; tp[2] = 32'h00000000;
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tb_[i]);
      run_op(0, exp_prod, d_at, b_cnt, d_cnt, early);
      exp_prod = tp[i];
      checks++;
      if (product !== exp_prod) begin
        failures++;
        $display("FAIL directed_product[%0d] got=%h required=%h", i, product, exp_prod);
      end
      checks++;
      if (d_at != 17 || d_cnt != 1 || b_cnt != 16) begin
        failures++;
        $display("FAIL directed_timing[%0d] done_at=%0d dones=%0d busy=%0d required 17 1 16", i, d_at, d_cnt, b_cnt);
      end
      checks++;
      if (early) begin
        failures++;
        $display("FAIL directed_hold[%0d] product changed before done, required stable", i);
      end
    end
  endtask

  task automatic test_start_ignored();
    int d_at, b_cnt, d_cnt;
    bit early;
    logic [15:0] a;
    logic [15:0] b;
    issue(16'h00FF, 16'h0101);
    run_op(5, exp_prod, d_at, b_cnt, d_cnt, early);
    exp_prod = 32'h0000FFFF;
    checks++;
    if (product !== exp_prod || d_at != 17 || b_cnt != 16) begin
      failures++;
      $display("FAIL start_in_calc product=%h done_at=%0d busy=%0d required %h 17 16", product, d_at, b_cnt, exp_prod);
    end
    a = 16'($urandom);
    b = 16'($urandom);
    issue(a, b);
    run_op(17, exp_prod, d_at, b_cnt, d_cnt, early);
    exp_prod = {16'h0, a} * {16'h0, b};
    checks++;
    if (product !== exp_prod || b_cnt != 16 || d_cnt != 1) begin
      failures++;
      $display("FAIL start_in_done product=%h busy=%0d dones=%0d required %h 16 1", product, b_cnt, d_cnt, exp_prod);
    end
  endtask

  task automatic test_reset_mid_calc();
    int d_at, b_cnt, d_cnt;
    bit early;
    issue(16'h8000, 16'h0002);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      failures++;
      $display("FAIL reset_abort busy=%b done=%b product=%h required 0 0 0", busy, done, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_prod = 32'h0;
    d_cnt = 0;
    b_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) d_cnt++;
      if (busy === 1'b1) b_cnt++;
    end
    checks++;
    if (d_cnt != 0 || b_cnt != 0) begin
      failures++;
      $display("FAIL reset_no_done dones=%0d busy=%0d required 0 0", d_cnt, b_cnt);
    end
    issue(16'h0007, 16'h0009);
    run_op(0, exp_prod, d_at, b_cnt, d_cnt, early);
    exp_prod = 32'h0000003F;
    checks++;
    if (product !== exp_prod || d_at != 17) begin
      failures++;
      $display("FAIL reset_restart product=%h done_at=%0d required %h 17", product, d_at, exp_prod);
    end
  endtask

  task automatic test_random();
    int d_at, b_cnt, d_cnt;
    bit early;
    logic [15:0] a;
    logic [15:0] b;
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i == 3) a = 16'hFFFF;
      if (i == 7) b = 16'h8001;
      issue(a, b);
      run_op(0, exp_prod, d_at, b_cnt, d_cnt, early);
      exp_prod = {16'h0, a} * {16'h0, b};
      checks++;
      if (product !== exp_prod || d_at != 17 || b_cnt != 16 || d_cnt != 1 || early) begin
        failures++;
        $display("FAIL random[%0d] %h*%h got=%h done_at=%0d busy=%0d early=%b required %h 17 16 0",
                 i, a, b, product, d_at, b_cnt, early, exp_prod);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int last_at = -1;
    @(negedge clk);
    mcand  = 16'h0010;
    mplier = 16'h0010;
    start  = 1'b1;
    exp_prod = 32'h00000100;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        checks++;
        if (product !== exp_prod || c != (last_at < 0 ? 17 : last_at + 18)) begin
          failures++;
          $display("FAIL b2b_done[%0d] cycle=%0d product=%h required cycle %0d product %h",
                   n_done, c, product, (last_at < 0 ? 17 : last_at + 18), exp_prod);
        end
        last_at = c;
      end
    end
    start = 1'b0;
    checks++;
    if (n_done != 4) begin
      failures++;
      $display("FAIL b2b_count dones=%0d required 4", n_done);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (quiet_viol != 0) begin
      failures++;
      $display("FAIL adder_quiet violations=%0d required 0", quiet_viol);
    end
  endtask

  initial begin
    start    = 1'b0;
    mcand    = 16'h0;
    mplier   = 16'h0;
    rst_n    = 1'b0;
    exp_prod = 32'h0;
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid_calc();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
